// File: rtl/seg_scan_driver_pkg.sv
// Shared types, constants and helpers for the multiplexed 4-digit seven-segment driver.
// Segment patterns are active-low, ordered g..a as bits 6..0.
package seg_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [3:0]  ITER_N    = 4'd14;
  localparam logic [13:0] VALUE_MAX = 14'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[14:0], bit_in};
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational BCD nibble to active-low segment decoder; dash outranks blank.
module seg_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] idigit,
  input  logic       iblank,
  input  logic       idash,
  output logic [6:0] oseg
);

  always_comb begin
    if (idash) begin
      oseg = SEG_DASH;
    end else if (iblank) begin
      oseg = SEG_BLANK;
    end else begin
      oseg = seg_pattern(idigit);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Loads a 14-bit binary value, converts it to BCD over 14 cycles, commits it to the
// display register and drives the externally scanned digit with one cycle of latency.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
(
  input  logic        iclk,
  input  logic        ireset,
  input  logic [3:0]  ivsel,
  input  logic [13:0] ivalue,
  input  logic [3:0]  idp,
  input  logic        ivalid,
  input  logic        iblank_lz,
  output logic        oready,
  output logic        odone,
  output logic        oovf,
  output logic [3:0]  oan,
  output logic [6:0]  oseg,
  output logic        odp
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  dp_lat_q, dp_lat_d;
  logic        ovf_lat_q, ovf_lat_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic        ovf_q, ovf_d;
  logic        odone_q, odone_d;
  logic        oready_q, oready_d;
  logic [3:0]  oan_q, oan_d;
  logic [6:0]  oseg_q, oseg_d;
  logic        odp_q, odp_d;

  logic [15:0] bcd_next_s;
  logic        onehot_s;
  logic [1:0]  sel_idx_s;
  logic [3:0]  nibble_s;
  logic [3:0]  zero_s;
  logic        blank_s;
  logic [6:0]  seg_dec_s;

  assign bcd_next_s = dd_step(bcd_q, bin_q[13]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    dp_lat_d  = dp_lat_q;
    ovf_lat_d = ovf_lat_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    ovf_d     = ovf_q;
    odone_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (ivalid && oready_q) begin
          state_d   = ST_CONV;
          ovf_lat_d = (ivalue > VALUE_MAX);
          bin_d     = (ivalue > VALUE_MAX) ? VALUE_MAX : ivalue;
          bcd_d     = 16'd0;
          dp_lat_d  = idp;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_d = bcd_next_s;
        bin_d = {bin_q[12:0], 1'b0};
        if (cnt_q == ITER_N - 4'd1) begin
          // The last iteration's result goes straight into the display register.
          state_d   = ST_COMMIT;
          cnt_d     = 4'd0;
          disp_d    = bcd_next_s;
          disp_dp_d = dp_lat_q;
          ovf_d     = ovf_lat_q;
          odone_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    oready_d = (state_d == ST_IDLE);
  end

  always_comb begin
    onehot_s = (ivsel != 4'd0) && ((ivsel & (ivsel - 4'd1)) == 4'd0);
    case (ivsel)
      4'b0001: sel_idx_s = 2'd0;
      4'b0010: sel_idx_s = 2'd1;
      4'b0100: sel_idx_s = 2'd2;
      4'b1000: sel_idx_s = 2'd3;
      default: sel_idx_s = 2'd0;
    endcase
    for (int i = 0; i < 4; i++) begin
      zero_s[i] = (disp_q[4*i +: 4] == 4'd0);
    end
    nibble_s = disp_q[{sel_idx_s, 2'b00} +: 4];
    // A digit is a leading zero when it and every digit to its left are zero.
    case (sel_idx_s)
      2'd1:    blank_s = iblank_lz && zero_s[1] && zero_s[2] && zero_s[3];
      2'd2:    blank_s = iblank_lz && zero_s[2] && zero_s[3];
      2'd3:    blank_s = iblank_lz && zero_s[3];
      default: blank_s = 1'b0;
    endcase
  end

  seg_decode u_seg_decode (
    .idigit (nibble_s),
    .iblank (blank_s),
    .idash  (ovf_q),
    .oseg   (seg_dec_s)
  );

  always_comb begin
    if (onehot_s) begin
      oan_d  = ~ivsel;
      oseg_d = seg_dec_s;
      odp_d  = ~disp_dp_q[sel_idx_s];
    end else begin
      oan_d  = 4'b1111;
      oseg_d = SEG_BLANK;
      odp_d  = 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      bin_q     <= 14'd0;
      bcd_q     <= 16'd0;
      dp_lat_q  <= 4'd0;
      ovf_lat_q <= 1'b0;
      disp_q    <= 16'd0;
      disp_dp_q <= 4'd0;
      ovf_q     <= 1'b0;
      odone_q   <= 1'b0;
      oready_q  <= 1'b1;
      oan_q     <= 4'b1111;
      oseg_q    <= SEG_BLANK;
      odp_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      dp_lat_q  <= dp_lat_d;
      ovf_lat_q <= ovf_lat_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      ovf_q     <= ovf_d;
      odone_q   <= odone_d;
      oready_q  <= oready_d;
      oan_q     <= oan_d;
      oseg_q    <= oseg_d;
      odp_q     <= odp_d;
    end
  end

  assign oready = oready_q;
  assign odone  = odone_q;
  assign oovf   = ovf_q;
  assign oan    = oan_q;
  assign oseg   = oseg_q;
  assign odp    = odp_q;

endmodule
